// File: rtl/keypad_scan_fifo_if.sv
// keypad_scan_fifo_if
//   Bundles the keypad lines and the key-code FIFO read port.
//   master : the scanner/FIFO block (senses row, takes read, drives the rest)
//   slave  : the keypad plus the consumer (drives row and read)
//   row      - active-low key sense lines, asynchronous to the clock
//   read     - pop request for the FIFO head
//   col      - one-cold active-low column drive
//   code     - key code at the FIFO head (0 when empty)
//   valid    - FIFO not empty
//   count    - FIFO occupancy, 0..FIFO_DEPTH
//   overflow - sticky flag: a completed press was dropped on a full FIFO
interface keypad_scan_fifo_if #(
    parameter int NROWS      = 4,
    parameter int NCOLS      = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CODE_W = $clog2(NROWS * NCOLS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [NROWS-1:0]  row;
    logic              read;
    logic [NCOLS-1:0]  col;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        input  row, read,
        output col, code, valid, count, overflow
    );

    modport slave (
        output row, read,
        input  col, code, valid, count, overflow
    );
endinterface

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Scans an NROWS x NCOLS active-low keypad one column at a time, debounces
//   press and release, and queues one key code per completed press in a small
//   FIFO. Code = r*NCOLS + c, lowest pressed row wins within a column.
//   clock - single clock, rising edge
//   reset - asynchronous, active-low
//   kp    - keypad_scan_fifo_if.master (row, read in; col, code, valid,
//           count, overflow out)
module keypad_scan_fifo #(
    parameter int NROWS      = 4,
    parameter int NCOLS      = 4,
    parameter int DEBOUNCE   = 4,
    parameter int SCAN_DWELL = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    keypad_scan_fifo_if.master kp
);
    localparam int CODE_W = $clog2(NROWS * NCOLS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CIDX_W = $clog2(NCOLS);
    localparam int DWL_W  = $clog2(SCAN_DWELL);
    localparam int DEB_W  = $clog2(DEBOUNCE);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    function automatic logic [NCOLS-1:0] col_drive(input logic [CIDX_W-1:0] idx);
        return ~(NCOLS'(1) << idx);
    endfunction

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [NROWS-1:0] row_meta;
    logic [NROWS-1:0] row_sync;

    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
        end
    end

    // ------------------------------------------------------------------
    // Scan / debounce FSM
    // ------------------------------------------------------------------
    state_t            state;
    logic [CIDX_W-1:0] col_idx;
    logic [DWL_W-1:0]  dwell;
    logic [DEB_W-1:0]  deb_cnt;
    logic [NROWS-1:0]  captured;
    logic [NCOLS-1:0]  col_q;
    logic              started;

    logic              row_low;
    logic              row_match;
    logic [CIDX_W-1:0] col_inc;
    logic [CODE_W-1:0] key_code;
    logic              push_req;

    assign row_low   = (row_sync != '1);
    assign row_match = (row_sync == captured);
    assign col_inc   = (col_idx == CIDX_W'(NCOLS - 1)) ? '0 : col_idx + 1'b1;
    assign push_req  = (state == ST_DEBOUNCE) && row_match &&
                       (deb_cnt == DEB_W'(DEBOUNCE - 1));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    // Descending loop: the last hit is the lowest-indexed low row.
    always_comb begin
        key_code = '0;
        for (int r = NROWS - 1; r >= 0; r--) begin
            if (!captured[r]) begin
                key_code = CODE_W'(r * NCOLS + int'(col_idx));
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_SCAN;
            col_idx  <= '0;
            dwell    <= '0;
            deb_cnt  <= '0;
            captured <= '1;
            col_q    <= '1;
            started  <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (!started) begin
                        // First edge out of reset: start driving column 0
                        // with a full dwell ahead of it.
                        started <= 1'b1;
                        col_q   <= col_drive(col_idx);
                    end else if (dwell >= DWL_W'(2) && row_low) begin
                        // Dwell 0/1 still sees the previous column through
                        // the synchronizer, so only dwell >= 2 is trusted.
                        captured <= row_sync;
                        deb_cnt  <= '0;
                        state    <= ST_DEBOUNCE;
                    end else if (dwell == DWL_W'(SCAN_DWELL - 1)) begin
                        col_idx <= col_inc;
                        col_q   <= col_drive(col_inc);
                        dwell   <= '0;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!row_match) begin
                        dwell <= '0;
                        state <= ST_SCAN;
                    end else if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                        state <= ST_HELD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                ST_HELD: begin
                    if (!row_low) begin
                        deb_cnt <= '0;
                        state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (row_low) begin
                        state <= ST_HELD;
                    end else if (deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
                        col_idx <= col_inc;
                        col_q   <= col_drive(col_inc);
                        dwell   <= '0;
                        state   <= ST_SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: state <= ST_SCAN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Key-code FIFO
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_pop  = kp.read && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push_req && (!full || do_pop);

    // NOTE: the storage array has no reset; it is only observed through
    // valid-gated code, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= key_code;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && full && !do_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign kp.col      = col_q;
    assign kp.valid    = (count_q != '0);
    assign kp.code     = (count_q != '0) ? mem[rd_ptr] : '0;
    assign kp.count    = count_q;
    assign kp.overflow = overflow_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo
//   Self-checking bench for keypad_scan_fifo with default parameters.
//   A keypad model pulls row[r] low only while a pressed key's column is
//   driven low; expected codes are queued when a press is driven and popped
//   and compared when the FIFO is read.
module tb_keypad_scan_fifo;
    localparam int NROWS      = 4;
    localparam int NCOLS      = 4;
    localparam int DEBOUNCE   = 4;
    localparam int SCAN_DWELL = 4;
    localparam int FIFO_DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    keypad_scan_fifo_if #(
        .NROWS(NROWS), .NCOLS(NCOLS), .FIFO_DEPTH(FIFO_DEPTH)
    ) kp ();

    keypad_scan_fifo #(
        .NROWS(NROWS), .NCOLS(NCOLS), .DEBOUNCE(DEBOUNCE),
        .SCAN_DWELL(SCAN_DWELL), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp   (kp.master)
    );

    // Keypad model
    logic [NROWS*NCOLS-1:0] key_down;
    logic [NROWS-1:0]       row_drv;

    always_comb begin
        row_drv = '1;
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (key_down[r*NCOLS + c] && !kp.col[c]) begin
                    row_drv[r] = 1'b0;
                end
            end
        end
    end

    assign kp.row = row_drv;

    // Scoreboard
    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    bit exp_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCOLS-1:0] col_pat(input int c);
        logic [NCOLS-1:0] p;
        p    = '1;
        p[c] = 1'b0;
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"},      kp.col,      32'hF);
        check({tag, "_code"},     kp.code,     32'h0);
        check({tag, "_valid"},    kp.valid,    32'h0);
        check({tag, "_count"},    kp.count,    32'h0);
        check({tag, "_overflow"}, kp.overflow, 32'h0);
    endtask

    task automatic do_reset();
        key_down = '0;
        kp.read  = 1'b0;
        reset    = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        exp_q.delete();
        exp_ovf = 1'b0;
        reset   = 1'b1;
    endtask

    task automatic wait_col(input int c, input bit want_on, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((kp.col == col_pat(c)) == want_on) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Press the keys in `rows` of column c. The column turns on at edge Ea;
    // the first sampling edge is Ea+1, so the push lands on Ea+3+DEBOUNCE.
    task automatic press_key(input int c, input logic [NROWS-1:0] rows, input int code,
                             input int hold, input bit pop_in_push);
        bit ok;
        wait_col(c, 1'b0, ok);
        check("col_leave_timeout", ok, 1);
        for (int r = 0; r < NROWS; r++) begin
            if (rows[r]) key_down[r*NCOLS + c] = 1'b1;
        end
        wait_col(c, 1'b1, ok);
        check("col_reach_timeout", ok, 1);
        repeat (DEBOUNCE + 2) @(negedge clock);
        check("pre_push_count", kp.count, exp_q.size());
        if (pop_in_push) begin
            check("push_pop_head", kp.code, exp_q[0]);
            kp.read = 1'b1;
        end
        @(negedge clock);
        kp.read = 1'b0;
        if (pop_in_push) void'(exp_q.pop_front());
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(code);
        else exp_ovf = 1'b1;
        check("push_count", kp.count, exp_q.size());
        check("push_overflow", kp.overflow, exp_ovf);
        repeat (hold) @(negedge clock);
        key_down = '0;
        repeat (20) @(negedge clock);
        check("post_release_count", kp.count, exp_q.size());
    endtask

    task automatic read_one();
        check("read_valid", kp.valid, 1);
        check("read_code", kp.code, exp_q[0]);
        kp.read = 1'b1;
        @(negedge clock);
        kp.read = 1'b0;
        void'(exp_q.pop_front());
        check("after_read_count", kp.count, exp_q.size());
        if (exp_q.size() == 0) begin
            check("after_read_valid", kp.valid, 0);
            check("after_read_code", kp.code, 0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        key_down = '0;
        kp.read  = 1'b0;
        exp_ovf  = 1'b0;

        // Idle scan: four cycles per column, wrapping, nothing queued.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            check("idle_col", kp.col, col_pat(((k - 1) / SCAN_DWELL) % NCOLS));
        end
        check("idle_valid", kp.valid, 0);

        // Single key row1/col2 held 30 cycles.
        press_key(2, 4'b0010, 6, 30, 1'b0);
        check("single_valid", kp.valid, 1);
        check("single_code", kp.code, 6);
        read_one();

        // Read while empty is ignored.
        kp.read = 1'b1;
        repeat (3) @(negedge clock);
        kp.read = 1'b0;
        check("underflow_count", kp.count, 0);
        check("underflow_valid", kp.valid, 0);

        // Bounce on row0/col0: never stable long enough to push.
        for (int i = 0; i < 10; i++) begin
            key_down[0] = 1'b1;
            repeat (2) @(negedge clock);
            key_down[0] = 1'b0;
            @(negedge clock);
        end
        repeat (20) @(negedge clock);
        check("bounce_count", kp.count, 0);
        check("bounce_valid", kp.valid, 0);

        // Five keys, no reads: fifth is dropped and overflow sticks.
        press_key(1, 4'b0001,  1, 10, 1'b0);
        press_key(0, 4'b0010,  4, 10, 1'b0);
        press_key(3, 4'b0010,  7, 10, 1'b0);
        press_key(2, 4'b0100, 10, 10, 1'b0);
        press_key(3, 4'b1000, 15, 10, 1'b0);
        check("full_count", kp.count, 4);
        check("full_overflow", kp.overflow, 1);
        for (int i = 0; i < 4; i++) read_one();
        check("drained_overflow", kp.overflow, 1);

        // Full FIFO with a pop in the push cycle: no drop.
        do_reset();
        press_key(2, 4'b0001,  2, 8, 1'b0);
        press_key(0, 4'b0100,  8, 8, 1'b0);
        press_key(1, 4'b1000, 13, 8, 1'b0);
        press_key(3, 4'b0001,  3, 8, 1'b0);
        press_key(1, 4'b0100,  9, 8, 1'b1);
        check("pushpop_count", kp.count, 4);
        check("pushpop_overflow", kp.overflow, 0);
        for (int i = 0; i < 4; i++) read_one();

        // Two keys in one column: lowest row wins.
        press_key(2, 4'b1010, 6, 8, 1'b0);
        read_one();

        // Reset in the middle of debouncing key code 5 (row1/col1).
        wait_col(1, 1'b0, ok);
        check("col_leave_timeout", ok, 1);
        key_down[1*NCOLS + 1] = 1'b1;
        wait_col(1, 1'b1, ok);
        check("col_reach_timeout", ok, 1);
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("midreset");
        key_down = '0;
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clock);
        check("midreset_first_col", kp.col, 32'hE);
        check("midreset_count", kp.count, 0);
        repeat (20) @(negedge clock);
        check("midreset_late_count", kp.count, 0);
        check("midreset_late_valid", kp.valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
